bit_serial_add_ctrl: RTL

//  Upstream sequencer for the bit-serial adder: accepts operand pairs on a valid/ready

---
 rtl/bit_serial_add_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/bit_serial_add_ctrl.sv
// Sequencer for a bit-serial adder: accepts an operand pair, runs clear/load/W shifts, holds the result.
// Optional BSA_OVF_EN adds out_ovf, the signed overflow flag captured alongside the sum.
module bit_serial_add_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    output logic             add_mode,
    output logic             add_clr,
    input  logic [W-1:0]     add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_cout,
`ifdef BSA_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        CAPT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

`ifdef BSA_OVF_EN
    // Two operands of equal sign whose sum flips sign have left the signed range.
    function automatic logic signed_ovf(input logic signed [W-1:0] a,
                                        input logic signed [W-1:0] b,
                                        input logic signed [W-1:0] s);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
            done_cnt  <= '0;
`ifdef BSA_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        add_a <= in_a;
                        add_b <= in_b;
                        state <= CLR;
                    end
                end
                CLR:  state <= LOAD;
                LOAD: begin
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        state <= CAPT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Adder sum register is complete after the last shift edge.
                CAPT: begin
                    out_sum   <= add_sum;
                    out_cout  <= add_cout;
                    out_valid <= 1'b1;
`ifdef BSA_OVF_EN
                    out_ovf   <= signed_ovf(add_a, add_b, add_sum);
`endif
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done_cnt  <= done_cnt + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign add_mode = (state != SHIFT);
    assign add_clr  = (state == CLR);

endmodule
